// File: rtl/pipe_pkg.sv
// Shared types and constants for the generic pipeline-stage register.
// The EX/MEM data layout is {pc, zero, alu_result, write_data, write_reg}, LSB first from write_reg.
package pipe_pkg;

    localparam int unsigned PIPE_CTRL_W = 5;
    localparam int unsigned PIPE_DATA_W = 102;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    localparam int unsigned EXMEM_WREG_LSB  = 0;
    localparam int unsigned EXMEM_WREG_W    = 5;
    localparam int unsigned EXMEM_WDATA_LSB = 5;
    localparam int unsigned EXMEM_WDATA_W   = 32;
    localparam int unsigned EXMEM_ALU_LSB   = 37;
    localparam int unsigned EXMEM_ALU_W     = 32;
    localparam int unsigned EXMEM_ZERO_BIT  = 69;
    localparam int unsigned EXMEM_PC_LSB    = 70;
    localparam int unsigned EXMEM_PC_W      = 32;

    function automatic logic [PIPE_DATA_W-1:0] exmem_pack(
        input logic [31:0] pc,
        input logic        zero,
        input logic [31:0] alu_result,
        input logic [31:0] write_data,
        input logic [4:0]  write_reg
    );
        return {pc, zero, alu_result, write_data, write_reg};
    endfunction

    function automatic logic [1:0] skid_occupancy(input skid_state_t s);
        case (s)
            EMPTY:   return 2'd0;
            ONE:     return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter: counts cycles with inc high and sticks at all-ones.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register with valid/ready handshake, flush,
// bubble-safe control and an optional 2-entry skid buffer.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = PIPE_CTRL_W,
    parameter int unsigned DATA_W = PIPE_DATA_W,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    if (SKID != 0) begin : g_skid
        skid_state_t       state_q, state_d;
        logic              valid_q, ready_q;
        logic [1:0]        occ_q;
        logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
        logic [DATA_W-1:0] head_data_q, head_data_d;
        logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
        logic [DATA_W-1:0] skid_data_q, skid_data_d;

        // Status outputs are registered from the next state so none of them decode state_q.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= EMPTY;
                valid_q <= 1'b0;
                ready_q <= 1'b1;
                occ_q   <= 2'd0;
            end else begin
                state_q <= state_d;
                valid_q <= (state_d != EMPTY);
                ready_q <= (state_d != FULL);
                occ_q   <= skid_occupancy(state_d);
            end
        end

        always_comb begin
            state_d = state_q;
            if (flush) begin
                state_d = EMPTY;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (in_fire) state_d = ONE;
                    end
                    ONE: begin
                        if (in_fire && !out_fire)      state_d = FULL;
                        else if (!in_fire && out_fire) state_d = EMPTY;
                    end
                    FULL: begin
                        if (out_fire) state_d = ONE;
                    end
                    default: state_d = EMPTY;
                endcase
            end
        end

        always_comb begin
            head_ctrl_d = head_ctrl_q;
            head_data_d = head_data_q;
            skid_ctrl_d = skid_ctrl_q;
            skid_data_d = skid_data_q;
            if (!flush) begin
                case (state_q)
                    EMPTY: begin
                        if (in_fire) begin
                            head_ctrl_d = in_ctrl;
                            head_data_d = in_data;
                        end
                    end
                    ONE: begin
                        if (in_fire && out_fire) begin
                            head_ctrl_d = in_ctrl;
                            head_data_d = in_data;
                        end else if (in_fire) begin
                            skid_ctrl_d = in_ctrl;
                            skid_data_d = in_data;
                        end
                    end
                    FULL: begin
                        if (out_fire) begin
                            head_ctrl_d = skid_ctrl_q;
                            head_data_d = skid_data_q;
                        end
                    end
                    default: ;
                endcase
            end
        end

        // Head control is stored pre-masked, so out_ctrl needs no gate after the flop.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                head_ctrl_q <= '0;
                head_data_q <= '0;
                skid_ctrl_q <= '0;
                skid_data_q <= '0;
            end else begin
                head_ctrl_q <= (state_d != EMPTY) ? head_ctrl_d : '0;
                head_data_q <= head_data_d;
                skid_ctrl_q <= skid_ctrl_d;
                skid_data_q <= skid_data_d;
            end
        end

        assign in_ready  = ready_q;
        assign out_valid = valid_q;
        assign out_ctrl  = head_ctrl_q;
        assign out_data  = head_data_q;
        assign occupancy = occ_q;
    end else begin : g_single
        logic              valid_q;
        logic [CTRL_W-1:0] ctrl_q;
        logic [DATA_W-1:0] data_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                ctrl_q  <= '0;
                data_q  <= '0;
            end else if (flush) begin
                valid_q <= 1'b0;
                ctrl_q  <= '0;
            end else if (in_fire) begin
                valid_q <= 1'b1;
                ctrl_q  <= in_ctrl;
                data_q  <= in_data;
            end else if (out_fire) begin
                valid_q <= 1'b0;
                ctrl_q  <= '0;
            end
        end

        assign in_ready  = !valid_q || out_ready;
        assign out_valid = valid_q;
        assign out_ctrl  = ctrl_q;
        assign out_data  = data_q;
        assign occupancy = {1'b0, valid_q};
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (out_valid && !out_ready),
        .count(stall_cnt)
    );

endmodule
